// File: rtl/hpdl_pkg.sv
// Shared HPDL-1414 display constants, the buffer-dump FSM state type and the
// character-set sanitiser used when the buffer is read back.
`timescale 1ns/1ps
package hpdl_pkg;

  localparam int         DISPLAY_LENGTH = 16;
  localparam logic [7:0] BKSP           = 8'h08;
  localparam logic [7:0] CR             = 8'h0D;
  localparam logic [7:0] LF             = 8'h0A;
  localparam logic [7:0] HPDL_CHAR_MIN  = 8'h20;
  localparam logic [7:0] HPDL_CHAR_MAX  = 8'h5F;
  localparam logic [7:0] SPACE          = 8'h20;

  typedef enum logic [2:0] {
    DUMP_IDLE,
    DUMP_FETCH,
    DUMP_WAIT,
    DUMP_LOAD,
    DUMP_SEND,
    DUMP_CR,
    DUMP_LF,
    DUMP_DONE
  } dump_state_e;

  // Which kind of frame is on the line, so SEND knows where to go afterwards.
  typedef enum logic [1:0] {
    FRAME_CHAR,
    FRAME_CR,
    FRAME_LF
  } frame_kind_e;

  // Codes the HPDL cannot show go out as a blank.
  function automatic logic [7:0] hpdl_sanitise(input logic [7:0] code);
    if (code >= HPDL_CHAR_MIN && code <= HPDL_CHAR_MAX) begin
      return {1'b0, code[6:0]};
    end
    return SPACE;
  endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// One 8N1 UART transmit frame (start, d0..d7 LSB first, stop) with every bit
// held for DIV clocks. A start pulse always reloads the frame and baud counter.
`timescale 1ns/1ps
module uart_tx_frame #(
  parameter int DIV = 104
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_txd,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam int               CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_cnt;
  logic [9:0]       shift_reg;

  // High during the last clock of the stop bit.
  assign o_frame_done = o_busy && (bit_cnt == 4'd9) && (baud_cnt == BAUD_LAST);
  assign o_txd        = shift_reg[0];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '1;
      o_busy    <= 1'b0;
    end else if (i_start) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= {1'b1, i_data, 1'b0};
      o_busy    <= 1'b1;
    end else if (o_busy) begin
      if (baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          o_busy <= 1'b0;
        end else begin
          bit_cnt   <= bit_cnt + 4'd1;
          shift_reg <= {1'b1, shift_reg[9:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/hpdl_buffer_uart_dump.sv
// Reads the HPDL character buffer through a second read port and sends it out
// on UART TX as one ASCII line, optionally terminated with CR/LF.
`timescale 1ns/1ps
module hpdl_buffer_uart_dump
  import hpdl_pkg::*;
#(
  parameter int CLK_HZ      = 12000000,
  parameter int BAUD        = 115200,
  parameter int DEPTH       = DISPLAY_LENGTH,
  parameter int ADDR_W      = 4,
  parameter int APPEND_CRLF = 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              i_dump_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [7:0]        i_rd_data,
  output logic              o_txd,
  output logic              o_busy,
  output logic              o_done
);

  localparam int                DIV        = (CLK_HZ + BAUD / 2) / BAUD;
  localparam logic [ADDR_W-1:0] LAST_PLACE = ADDR_W'(DEPTH - 1);

  dump_state_e       state_q, state_d;
  frame_kind_e       kind_q, kind_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              tx_frame_done;

  assign o_rd_addr = index_q;
  assign o_done    = (state_q == DUMP_DONE);
  assign o_busy    = tx_busy || (state_q != DUMP_IDLE && state_q != DUMP_DONE);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= DUMP_IDLE;
      kind_q  <= FRAME_CHAR;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      index_q <= index_d;
    end
  end

  // The read data is only meaningful in LOAD, two cycles after the address.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    index_d  = index_q;
    tx_start = 1'b0;
    tx_data  = hpdl_sanitise(i_rd_data);
    unique case (state_q)
      DUMP_IDLE: begin
        if (i_dump_req) begin
          state_d = DUMP_FETCH;
          index_d = '0;
        end
      end
      DUMP_FETCH: state_d = DUMP_WAIT;
      DUMP_WAIT:  state_d = DUMP_LOAD;
      DUMP_LOAD: begin
        tx_start = 1'b1;
        kind_d   = FRAME_CHAR;
        state_d  = DUMP_SEND;
      end
      DUMP_SEND: begin
        if (tx_frame_done) begin
          unique case (kind_q)
            FRAME_CHAR: begin
              if (index_q < LAST_PLACE) begin
                index_d = index_q + ADDR_W'(1);
                state_d = DUMP_FETCH;
              end else if (APPEND_CRLF != 0) begin
                state_d = DUMP_CR;
              end else begin
                state_d = DUMP_DONE;
              end
            end
            FRAME_CR: state_d = DUMP_LF;
            default:  state_d = DUMP_DONE;
          endcase
        end
      end
      DUMP_CR: begin
        tx_start = 1'b1;
        tx_data  = CR;
        kind_d   = FRAME_CR;
        state_d  = DUMP_SEND;
      end
      DUMP_LF: begin
        tx_start = 1'b1;
        tx_data  = LF;
        kind_d   = FRAME_LF;
        state_d  = DUMP_SEND;
      end
      default: state_d = DUMP_IDLE;
    endcase
  end

  uart_tx_frame #(
    .DIV (DIV)
  ) u_tx (
    .CLK          (CLK),
    .reset        (reset),
    .i_start      (tx_start),
    .i_data       (tx_data),
    .o_txd        (o_txd),
    .o_busy       (tx_busy),
    .o_frame_done (tx_frame_done)
  );

endmodule

// File: tb/tb_hpdl_buffer_uart_dump.sv
// Bench for the buffer dump: a behavioural buffer memory, a sampling UART
// receiver and a character-set model drive two instances (with and without CR/LF).
`timescale 1ns/1ps
module tb_hpdl_buffer_uart_dump;

  localparam int DEPTH = 16;
  localparam int BIT_CLKS = 104;

  logic       CLK;
  logic       reset;
  logic       dump_req, nc_dump_req;
  logic [3:0] rd_addr, nc_rd_addr;
  logic [7:0] rd_data, nc_rd_data;
  logic       txd, busy, done;
  logic       nc_txd, nc_busy, nc_done;

  logic [7:0] mem [DEPTH];
  int checks, passes;
  int done_count = 0;
  int nc_done_count = 0;

  hpdl_buffer_uart_dump #(.APPEND_CRLF(1)) dut (
    .CLK(CLK), .reset(reset), .i_dump_req(dump_req), .o_rd_addr(rd_addr),
    .i_rd_data(rd_data), .o_txd(txd), .o_busy(busy), .o_done(done)
  );

  hpdl_buffer_uart_dump #(.APPEND_CRLF(0)) dut_nc (
    .CLK(CLK), .reset(reset), .i_dump_req(nc_dump_req), .o_rd_addr(nc_rd_addr),
    .i_rd_data(nc_rd_data), .o_txd(nc_txd), .o_busy(nc_busy), .o_done(nc_done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Registered read port: data valid one cycle after the address.
  always @(posedge CLK) begin
    rd_data    <= mem[rd_addr];
    nc_rd_data <= mem[nc_rd_addr];
  end

  always @(negedge CLK) begin
    if (done === 1'b1) done_count++;
    if (nc_done === 1'b1) nc_done_count++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] expect_char(input logic [7:0] b);
    return (b >= 8'h20 && b <= 8'h5F) ? b : 8'h20;
  endfunction

  function automatic logic line_of(input bit nc);
    return nc ? nc_txd : txd;
  endfunction

  function automatic logic done_of(input bit nc);
    return nc ? nc_done : done;
  endfunction

  function automatic logic busy_of(input bit nc);
    return nc ? nc_busy : busy;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input bit nc);
    @(posedge CLK); #1;
    if (nc) nc_dump_req = 1'b1;
    else    dump_req    = 1'b1;
    @(posedge CLK); #1;
    dump_req    = 1'b0;
    nc_dump_req = 1'b0;
  endtask

  // Returns the number of negedges until the line is seen low, -1 on timeout.
  task automatic wait_start(input bit nc, input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge CLK);
      if (line_of(nc) === 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  // Called on the negedge where the start bit was first seen.
  task automatic rx_frame(input bit nc, output logic [7:0] data, output logic ok);
    logic [9:0] bits;
    logic       cur;
    ok = 1'b1;
    bits = '0;
    for (int b = 0; b < 10; b++) begin
      for (int j = 0; j < BIT_CLKS; j++) begin
        if (!(b == 0 && j == 0)) @(negedge CLK);
        cur = line_of(nc);
        if (j == 0) bits[b] = cur;
        else if (cur !== bits[b]) ok = 1'b0;
      end
    end
    ok   = ok && (bits[0] === 1'b0) && (bits[9] === 1'b1);
    data = bits[8:1];
  endtask

  task automatic receive_dump(input bit nc, input int n_frames, input int poke_after, input int poke_place,
                              input logic [7:0] poke_val, input string name, input bit check_done);
    logic [7:0] data, exp;
    logic       ok;
    int         n;
    for (int f = 0; f < n_frames; f++) begin
      if (f > 0) begin
        wait_start(nc, 2000, n);
        if (f < DEPTH) checkOutput($sformatf("%s gap before frame %0d", name, f), n, 4);
        else checkOutput($sformatf("%s start of frame %0d", name, f), (n > 0), 1);
      end
      rx_frame(nc, data, ok);
      checkOutput($sformatf("%s frame %0d timing", name, f), ok, 1);
      if (f < DEPTH) exp = expect_char(mem[f]);
      else exp = (f == DEPTH) ? 8'h0D : 8'h0A;
      checkOutput($sformatf("%s frame %0d data", name, f), data, exp);
      if (f == poke_after) mem[poke_place] = poke_val;
    end
    if (check_done) begin
      @(negedge CLK);
      checkOutput({name, " o_done after last stop bit"}, done_of(nc), 1);
      checkOutput({name, " o_busy low with o_done"}, busy_of(nc), 0);
    end
  endtask

  initial begin
    string      msg;
    int         n, done_before, nc_before;
    logic       idle_ok, ok;
    logic [7:0] data;

    checks = 0;
    passes = 0;
    reset = 1'b0;
    dump_req = 1'b0;
    nc_dump_req = 1'b0;
    msg = "HELLO WORLD 1234";
    for (int i = 0; i < DEPTH; i++) mem[i] = msg[i];

    #2 reset = 1'b1;
    #1;
    checkOutput("reset o_txd", txd, 1);
    checkOutput("reset o_busy", busy, 0);
    checkOutput("reset o_done", done, 0);
    checkOutput("reset o_rd_addr", rd_addr, 0);
    checkOutput("reset nc o_txd", nc_txd, 1);
    repeat (3) @(posedge CLK);
    #1 reset = 1'b0;

    $display("[TB] dump 1: HELLO WORLD 1234 with CR/LF and ignored requests");
    applyStimulus(0);
    done_before = done_count;
    checkOutput("dump1 busy after request", busy, 1);
    wait_start(0, 50, n);
    checkOutput("dump1 request to start bit latency", n, 4);
    fork
      receive_dump(0, DEPTH + 2, -1, 0, 8'h00, "dump1", 1'b1);
      begin
        repeat (2500) @(posedge CLK);
        #1 dump_req = 1'b1;
        @(posedge CLK); #1 dump_req = 1'b0;
        repeat (7000) @(posedge CLK);
        #1 dump_req = 1'b1;
        @(posedge CLK); #1 dump_req = 1'b0;
      end
    join
    dump_req = 1'b1;
    @(posedge CLK); #1 dump_req = 1'b0;
    idle_ok = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      if (busy !== 1'b0 || txd !== 1'b1) idle_ok = 1'b0;
    end
    checkOutput("request in DONE cycle ignored", idle_ok, 1);
    #1 checkOutput("dump1 single o_done pulse", done_count - done_before, 1);

    $display("[TB] dump 2: random buffer, sanitiser and write during dump");
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[2]  = 8'h08;
    mem[6]  = 8'h7A;
    mem[9]  = 8'h00;
    mem[13] = 8'h5F;
    applyStimulus(0);
    done_before = done_count;
    wait_start(0, 50, n);
    checkOutput("dump2 latency", n, 4);
    receive_dump(0, DEPTH + 2, 3, 10, 8'($urandom_range(0, 255)), "dump2", 1'b1);
    @(posedge CLK); #1 dump_req = 1'b1;
    checkOutput("dump2 single o_done pulse", done_count - done_before, 1);
    @(posedge CLK); #1 dump_req = 1'b0;
    checkOutput("request after DONE accepted", busy, 1);
    wait_start(0, 50, n);
    checkOutput("dump3 latency", n, 4);

    $display("[TB] dump 3: reset during frame 5 bit 3");
    done_before = done_count;
    receive_dump(0, 5, -1, 0, 8'h00, "dump3", 1'b0);
    wait_start(0, 2000, n);
    checkOutput("dump3 gap before frame 5", n, 4);
    repeat (3 * BIT_CLKS + 50) @(negedge CLK);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid-frame reset o_txd", txd, 1);
    checkOutput("mid-frame reset o_busy", busy, 0);
    checkOutput("mid-frame reset o_done", done, 0);
    repeat (200) @(posedge CLK);
    #1 checkOutput("no o_done after reset", done_count - done_before, 0);
    reset = 1'b0;
    applyStimulus(0);
    wait_start(0, 50, n);
    checkOutput("restart latency", n, 4);
    rx_frame(0, data, ok);
    checkOutput("restart frame timing", ok, 1);
    checkOutput("restart from place 0", data, expect_char(mem[0]));
    #2 reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;

    $display("[TB] dump 4: no CR/LF instance");
    nc_before = nc_done_count;
    applyStimulus(1);
    wait_start(1, 50, n);
    checkOutput("nocrlf latency", n, 4);
    receive_dump(1, DEPTH, -1, 0, 8'h00, "nocrlf", 1'b1);
    @(posedge CLK);
    #1 checkOutput("nocrlf single o_done pulse", nc_done_count - nc_before, 1);
    checkOutput("nocrlf line idle after dump", nc_txd, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
